// File: rtl/artemis_mcb_pkg.sv
// Shared types and constants for the Artemis MCB user-port controller.
// Optional read prefetch is enabled by defining ARTEMIS_MCB_PREFETCH_EN.
package artemis_mcb_pkg;

  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam logic [2:0] CMD_WRITE_PC = 3'b010;
  localparam logic [2:0] CMD_READ_PC  = 3'b011;
  localparam logic [2:0] CMD_REFRESH  = 3'b100;

  localparam int unsigned MCB_FIFO_DEPTH = 64;
  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned INSTR_W = 3;
  localparam int unsigned BL_W    = 6;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_FILL,
    WR_CMD,
    RD_CMD,
    RD_DRAIN,
    FINISH,
    ERR
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [BL_W-1:0]    bl;
    logic [ADDR_W-1:0]  byte_addr;
  } mcb_cmd_t;

  // MCB encodes burst length as words-1
  function automatic mcb_cmd_t make_cmd(input logic [INSTR_W-1:0] instr,
                                        input logic [CNT_W-1:0]   words,
                                        input logic [ADDR_W-1:0]  byte_addr);
    mcb_cmd_t c;
    c.instr     = instr;
    c.bl        = BL_W'(words - CNT_W'(1));
    c.byte_addr = byte_addr;
    return c;
  endfunction

endpackage

// File: rtl/artemis_mcb_port_ctrl_burst_calc.sv
// Burst sizing: min(remaining, BURST_MAX) plus the address/remaining after that burst.
module artemis_mcb_burst_calc
  import artemis_mcb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 32,
  parameter int unsigned LEN_W     = 24
) (
  input  logic [LEN_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic [LEN_W-1:0]  next_remaining
);

  always_comb begin
    burst          = (remaining < LEN_W'(BURST_MAX)) ? CNT_W'(remaining) : CNT_W'(BURST_MAX);
    next_addr      = addr + (ADDR_W'(burst) << 2);
    next_remaining = remaining - LEN_W'(burst);
  end

endmodule

// File: rtl/artemis_mcb_port_ctrl.sv
// Upstream driver for one Artemis DDR3 MCB user port: splits word transfers into bursts.
// Define ARTEMIS_MCB_PREFETCH_EN to allow a second read burst in flight while draining.
module artemis_mcb_port_ctrl
  import artemis_mcb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 32,
  parameter int unsigned LEN_W     = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                calibration_done,
  input  logic                req_wr,
  input  logic                req_rd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  output logic                req_ready,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [MASK_W-1:0]   wr_mask,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                p_cmd_en,
  output logic [INSTR_W-1:0]  p_cmd_instr,
  output logic [BL_W-1:0]     p_cmd_bl,
  output logic [ADDR_W-1:0]   p_cmd_byte_addr,
  input  logic                p_cmd_full,
  output logic                p_wr_en,
  output logic [MASK_W-1:0]   p_wr_mask,
  output logic [DATA_W-1:0]   p_wr_data,
  input  logic                p_wr_full,
  input  logic                p_wr_underrun,
  input  logic                p_wr_error,
  output logic                p_rd_en,
  input  logic [DATA_W-1:0]   p_rd_data,
  input  logic                p_rd_empty,
  input  logic                p_rd_overflow,
  input  logic                p_rd_error
);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d, next_addr;
  logic [LEN_W-1:0]    remaining, remaining_d, next_remaining;
  logic [CNT_W-1:0]    count, count_d, burst;
  logic                accept_c, fault_c;
  mcb_cmd_t            cmd_c;

  artemis_mcb_burst_calc #(
    .BURST_MAX (BURST_MAX),
    .LEN_W     (LEN_W)
  ) u_burst_calc (
    .remaining      (remaining),
    .addr           (addr),
    .burst          (burst),
    .next_addr      (next_addr),
    .next_remaining (next_remaining)
  );

  // Next state, datapath updates and the handshake-coupled MCB/user strobes
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    remaining_d = remaining;
    count_d     = count;
    cmd_c       = '0;
    p_cmd_en    = 1'b0;
    p_wr_en     = 1'b0;
    p_wr_mask   = '0;
    p_wr_data   = '0;
    p_rd_en     = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    req_ready   = (state == IDLE) && calibration_done;
    accept_c    = req_ready && (req_wr || req_rd);
    fault_c     = (state inside {WR_FILL, WR_CMD, RD_CMD, RD_DRAIN}) &&
                  (p_wr_underrun || p_wr_error || p_rd_overflow || p_rd_error ||
                   !calibration_done);

    case (state)
      IDLE: begin
        if (accept_c) begin
          addr_d      = req_addr;
          remaining_d = req_len;
          count_d     = '0;
          if (req_len == '0 || req_addr[1:0] != 2'b00) state_d = ERR;
          else if (req_wr)                             state_d = WR_FILL;
          else                                         state_d = RD_CMD;
        end
      end
      WR_FILL: begin
        wr_ready = !p_wr_full;
        if (wr_valid && !p_wr_full) begin
          p_wr_en   = 1'b1;
          p_wr_data = wr_data;
          p_wr_mask = wr_mask;
          count_d   = count + CNT_W'(1);
          if (count_d == burst) begin
            count_d = '0;
            state_d = WR_CMD;
          end
        end
      end
      WR_CMD: begin
        if (!p_cmd_full) begin
          p_cmd_en    = 1'b1;
          cmd_c       = make_cmd(CMD_WRITE, burst, addr);
          addr_d      = next_addr;
          remaining_d = next_remaining;
          state_d     = (next_remaining != '0) ? WR_FILL : FINISH;
        end
      end
      RD_CMD: begin
        if (!p_cmd_full) begin
          p_cmd_en    = 1'b1;
          cmd_c       = make_cmd(CMD_READ, burst, addr);
          addr_d      = next_addr;
          remaining_d = next_remaining;
          count_d     = count + burst;
          state_d     = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rd_valid = !p_rd_empty;
        rd_data  = p_rd_data;
        p_rd_en  = !p_rd_empty && rd_ready;
`ifdef ARTEMIS_MCB_PREFETCH_EN
        // count holds words commanded but not yet popped
        if (remaining != '0 && !p_cmd_full &&
            (SUM_W'(count) + SUM_W'(burst)) <= SUM_W'(MCB_FIFO_DEPTH)) begin
          p_cmd_en    = 1'b1;
          cmd_c       = make_cmd(CMD_READ, burst, addr);
          addr_d      = next_addr;
          remaining_d = next_remaining;
          count_d     = count + burst;
        end
        if (p_rd_en) count_d = count_d - CNT_W'(1);
        if (count_d == '0) state_d = (remaining_d != '0) ? RD_CMD : FINISH;
`else
        if (p_rd_en) begin
          count_d = count - CNT_W'(1);
          if (count_d == '0) state_d = (remaining != '0) ? RD_CMD : FINISH;
        end
`endif
      end
      FINISH:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any MCB fault or calibration loss aborts with every strobe withdrawn
    if (fault_c) begin
      state_d  = ERR;
      cmd_c    = '0;
      p_cmd_en = 1'b0;
      p_wr_en  = 1'b0;
      p_rd_en  = 1'b0;
      wr_ready = 1'b0;
      rd_valid = 1'b0;
    end

    p_cmd_instr     = cmd_c.instr;
    p_cmd_bl        = cmd_c.bl;
    p_cmd_byte_addr = cmd_c.byte_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      remaining <= remaining_d;
      count     <= count_d;
      busy      <= state_d inside {WR_FILL, WR_CMD, RD_CMD, RD_DRAIN};
      done      <= state_d inside {FINISH, ERR};
      if (state_d == ERR) error <= 1'b1;
      else if (accept_c)  error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_artemis_mcb_port_ctrl.sv
// Directed self-checking bench for artemis_mcb_port_ctrl with a small MCB FIFO model.
module tb_artemis_mcb_port_ctrl;

  localparam int unsigned LEN_W = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             calibration_done = 1'b0;
  logic             req_wr = 1'b0, req_rd = 1'b0;
  logic [29:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             req_ready, busy, done, error;
  logic [31:0]      wr_data;
  logic [3:0]       wr_mask = 4'h0;
  logic             wr_valid = 1'b0, wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid, rd_ready = 1'b0;
  logic             p_cmd_en;
  logic [2:0]       p_cmd_instr;
  logic [5:0]       p_cmd_bl;
  logic [29:0]      p_cmd_byte_addr;
  logic             p_cmd_full = 1'b0;
  logic             p_wr_en;
  logic [3:0]       p_wr_mask;
  logic [31:0]      p_wr_data;
  logic             p_wr_full = 1'b0, p_wr_underrun = 1'b0, p_wr_error = 1'b0;
  logic             p_rd_en;
  logic [31:0]      p_rd_data = '0;
  logic             p_rd_empty = 1'b1, p_rd_overflow = 1'b0, p_rd_error = 1'b0;

  int passed = 0, total = 0;

  // monitor state (written only by the negedge monitor)
  int cmd_n = 0, wr_n = 0, rd_n = 0, wr_seq = 0, rd_seq = 0;
  int done_cnt = 0, done_wide = 0, wr_err = 0, rd_err = 0, rd_viol = 0;
  int overlap = 0, outstanding = 0;
  logic [2:0]  log_instr [16];
  logic [5:0]  log_bl    [16];
  logic [29:0] log_addr  [16];
  int          log_rdn   [16];
  logic        prev_done = 1'b0;
  logic        s_pop = 1'b0, s_cmd_rd = 1'b0;
  int          s_cmd_words = 0;
  logic        clr = 1'b0;
  logic        gap_en = 1'b0;

  // read FIFO model state (written only by the posedge model)
  int rd_avail = 0, pop_idx = 0, cyc = 0;

  assign wr_data = 32'hD000_0000 + 32'(wr_seq);

  always #5 clk = ~clk;

  artemis_mcb_port_ctrl #(.BURST_MAX(32), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
    .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .busy(busy), .done(done), .error(error),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data),
    .p_wr_full(p_wr_full), .p_wr_underrun(p_wr_underrun), .p_wr_error(p_wr_error),
    .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty),
    .p_rd_overflow(p_rd_overflow), .p_rd_error(p_rd_error)
  );

  // Monitor: values at the negedge are what the next posedge commits
  always @(negedge clk) begin
    s_pop       = p_rd_en;
    s_cmd_rd    = p_cmd_en && (p_cmd_instr == 3'b001);
    s_cmd_words = int'(p_cmd_bl) + 1;
    if (clr) begin
      cmd_n = 0; wr_n = 0; rd_n = 0; done_cnt = 0;
      wr_err = 0; rd_err = 0; rd_viol = 0; overlap = 0;
    end else begin
      if (p_cmd_en) begin
        if (cmd_n < 16) begin
          log_instr[cmd_n] = p_cmd_instr;
          log_bl[cmd_n]    = p_cmd_bl;
          log_addr[cmd_n]  = p_cmd_byte_addr;
          log_rdn[cmd_n]   = rd_n;
        end
        if (s_cmd_rd && outstanding > 0) overlap++;
        cmd_n++;
      end
      if (p_wr_en) begin
        if (p_wr_data !== 32'hD000_0000 + 32'(wr_seq) || p_wr_mask !== wr_mask) wr_err++;
        wr_n++;
        wr_seq++;
      end
      if (rd_valid && rd_ready) begin
        if (rd_data !== 32'hA000_0000 + 32'(rd_seq)) rd_err++;
        rd_n++;
        rd_seq++;
      end
      if (p_rd_en !== (rd_valid && rd_ready) || (p_rd_en && (p_rd_empty || !rd_ready))) rd_viol++;
      if (done === 1'b1) begin
        done_cnt++;
        if (prev_done === 1'b1) done_wide++;
      end
    end
    if (s_cmd_rd) outstanding += s_cmd_words;
    if (s_pop) outstanding--;
    prev_done = done;
  end

  // First-word-fall-through read FIFO fed by read commands
  always @(posedge clk) begin
    #1;
    cyc++;
    if (s_cmd_rd) rd_avail += s_cmd_words;
    if (s_pop) begin
      rd_avail--;
      pop_idx++;
    end
    p_rd_data  = 32'hA000_0000 + 32'(pop_idx);
    p_rd_empty = (rd_avail <= 0) || (gap_en && (cyc % 3 == 0));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    @(posedge clk); #2;
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic issue_req(input logic wr, input logic rd, input logic [29:0] a,
                           input logic [LEN_W-1:0] n);
    @(posedge clk); #2;
    req_wr = wr; req_rd = rd; req_addr = a; req_len = n;
    @(posedge clk); #2;
    req_wr = 1'b0; req_rd = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else passed++;
    total++; if ({busy, done, error} !== 3'b000) $display("FAIL rst_status: got %b want 000", {busy, done, error}); else passed++;
    total++; if ({p_cmd_en, p_wr_en, p_rd_en} !== 3'b000) $display("FAIL rst_enables: got %b want 000", {p_cmd_en, p_wr_en, p_rd_en}); else passed++;
    total++; if (p_cmd_byte_addr !== 30'h0 || p_wr_data !== 32'h0) $display("FAIL rst_buses: got %h/%h want 0/0", p_cmd_byte_addr, p_wr_data); else passed++;
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL uncal_req_ready: got %b want 0", req_ready); else passed++;
    step(1);
    calibration_done = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL cal_req_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_write();
    int cy; bit ok;
    clear_logs();
    wr_mask = 4'h5;
    wr_valid = 1'b1;
    issue_req(1'b1, 1'b0, 30'h100, 24'd5);
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else passed++;
    wait_done(100, cy, ok);
    total++; if (!ok) $display("FAIL wr_done: got timeout want done pulse"); else passed++;
    total++; if (wr_n !== 5 || wr_err !== 0) $display("FAIL wr_words: got %0d words %0d bad want 5/0", wr_n, wr_err); else passed++;
    total++; if (cmd_n !== 1) $display("FAIL wr_cmd_count: got %0d want 1", cmd_n); else passed++;
    total++; if ({log_instr[0], log_bl[0], log_addr[0]} !== {3'b000, 6'd4, 30'h100})
      $display("FAIL wr_cmd: got instr %b bl %0d addr %h want 000/4/100", log_instr[0], log_bl[0], log_addr[0]); else passed++;
    total++; if (error !== 1'b0) $display("FAIL wr_error: got %b want 0", error); else passed++;
    wr_valid = 1'b0;
    step(3);
    total++; if (done_cnt !== 1 || wr_n !== 5) $display("FAIL wr_after: got done %0d words %0d want 1/5", done_cnt, wr_n); else passed++;
  endtask

  task automatic test_read_70();
    int cy; bit ok;
    logic [5:0]  exp_bl [3];
    logic [29:0] exp_addr [3];
    exp_bl   = '{6'd31, 6'd31, 6'd5};
    exp_addr = '{30'h200, 30'h280, 30'h300};
    clear_logs();
    rd_ready = 1'b1;
    issue_req(1'b0, 1'b1, 30'h200, 24'd70);
    wait_done(400, cy, ok);
    total++; if (!ok) $display("FAIL rd70_done: got timeout want done pulse"); else passed++;
    total++; if (cmd_n !== 3) $display("FAIL rd70_cmd_count: got %0d want 3", cmd_n); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({log_instr[i], log_bl[i], log_addr[i]} !== {3'b001, exp_bl[i], exp_addr[i]})
        $display("FAIL rd70_cmd%0d: got instr %b bl %0d addr %h want 001/%0d/%h",
                 i, log_instr[i], log_bl[i], log_addr[i], exp_bl[i], exp_addr[i]);
      else passed++;
    end
    total++; if (rd_n !== 70 || rd_err !== 0) $display("FAIL rd70_beats: got %0d beats %0d bad want 70/0", rd_n, rd_err); else passed++;
    total++; if (rd_viol !== 0) $display("FAIL rd70_pop_rule: got %0d violations want 0", rd_viol); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rd70_error: got %b want 0", error); else passed++;
    rd_ready = 1'b0;
  endtask

  task automatic test_cmd_full();
    int cy; bit ok;
    clear_logs();
    p_cmd_full = 1'b1;
    wr_mask = 4'hA;
    wr_valid = 1'b1;
    issue_req(1'b1, 1'b0, 30'h400, 24'd3);
    step(13);
    @(negedge clk);
    total++; if (cmd_n !== 0 || wr_n !== 3) $display("FAIL cf_stall: got cmds %0d words %0d want 0/3", cmd_n, wr_n); else passed++;
    total++; if (busy !== 1'b1 || wr_ready !== 1'b0) $display("FAIL cf_hold: got busy %b wr_ready %b want 1/0", busy, wr_ready); else passed++;
    step(1);
    p_cmd_full = 1'b0;
    wait_done(20, cy, ok);
    total++; if (!ok) $display("FAIL cf_done: got timeout want done pulse"); else passed++;
    total++; if (cmd_n !== 1 || {log_instr[0], log_bl[0], log_addr[0]} !== {3'b000, 6'd2, 30'h400})
      $display("FAIL cf_cmd: got %0d cmds instr %b bl %0d addr %h want 1 of 000/2/400", cmd_n, log_instr[0], log_bl[0], log_addr[0]); else passed++;
    total++; if (wr_n !== 3 || wr_err !== 0) $display("FAIL cf_words: got %0d words %0d bad want 3/0", wr_n, wr_err); else passed++;
    wr_valid = 1'b0;
  endtask

  task automatic test_rd_gaps();
    bit ok;
    ok = 1'b0;
    clear_logs();
    gap_en = 1'b1;
    rd_ready = 1'b0;
    issue_req(1'b0, 1'b1, 30'h800, 24'd10);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      rd_ready = !rd_ready;
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL gap_done: got timeout want done pulse"); else passed++;
    total++; if (rd_n !== 10 || rd_err !== 0) $display("FAIL gap_beats: got %0d beats %0d bad want 10/0", rd_n, rd_err); else passed++;
    total++; if (rd_viol !== 0) $display("FAIL gap_pop_rule: got %0d violations want 0", rd_viol); else passed++;
    total++; if (cmd_n !== 1 || log_bl[0] !== 6'd9 || log_addr[0] !== 30'h800)
      $display("FAIL gap_cmd: got %0d cmds bl %0d addr %h want 1/9/800", cmd_n, log_bl[0], log_addr[0]); else passed++;
    gap_en = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_bad_req();
    int cy; bit ok;
    clear_logs();
    wr_valid = 1'b1;
    issue_req(1'b1, 1'b0, 30'h102, 24'd4);
    wait_done(5, cy, ok);
    total++; if (!ok || cy !== 1) $display("FAIL bad_addr_done: got ok %b after %0d want 1 after 1", ok, cy); else passed++;
    total++; if (error !== 1'b1) $display("FAIL bad_addr_error: got %b want 1", error); else passed++;
    total++; if (cmd_n !== 0 || wr_n !== 0) $display("FAIL bad_addr_traffic: got cmds %0d words %0d want 0/0", cmd_n, wr_n); else passed++;
    step(3);
    total++; if (error !== 1'b1 || busy !== 1'b0) $display("FAIL bad_sticky: got error %b busy %b want 1/0", error, busy); else passed++;
    wr_valid = 1'b0;
    issue_req(1'b0, 1'b1, 30'h40, 24'd0);
    wait_done(5, cy, ok);
    total++; if (!ok || error !== 1'b1 || cmd_n !== 0) $display("FAIL bad_len: got ok %b error %b cmds %0d want 1/1/0", ok, error, cmd_n); else passed++;
    rd_ready = 1'b1;
    issue_req(1'b0, 1'b1, 30'h40, 24'd2);
    @(negedge clk);
    total++; if (error !== 1'b0) $display("FAIL err_clear: got %b want 0", error); else passed++;
    wait_done(50, cy, ok);
    total++; if (!ok || cmd_n !== 1 || rd_n !== 2 || error !== 1'b0)
      $display("FAIL good_after_bad: got ok %b cmds %0d beats %0d error %b want 1/1/2/0", ok, cmd_n, rd_n, error); else passed++;
    rd_ready = 1'b0;
  endtask

  task automatic test_read_64();
    int cy; bit ok;
    clear_logs();
    rd_ready = 1'b1;
    issue_req(1'b0, 1'b1, 30'h0, 24'd64);
    wait_done(300, cy, ok);
    total++; if (!ok) $display("FAIL rd64_done: got timeout want done pulse"); else passed++;
    total++; if (cmd_n !== 2 || log_addr[1] !== 30'h80 || log_bl[1] !== 6'd31)
      $display("FAIL rd64_cmds: got %0d cmds second at %h bl %0d want 2/80/31", cmd_n, log_addr[1], log_bl[1]); else passed++;
    total++; if (rd_n !== 64 || rd_err !== 0) $display("FAIL rd64_beats: got %0d beats %0d bad want 64/0", rd_n, rd_err); else passed++;
`ifdef ARTEMIS_MCB_PREFETCH_EN
    total++; if (!(log_rdn[1] < 32)) $display("FAIL rd64_prefetch: got second cmd after %0d beats want under 32", log_rdn[1]); else passed++;
`else
    total++; if (log_rdn[1] !== 32 || overlap !== 0)
      $display("FAIL rd64_single: got second cmd after %0d beats overlap %0d want 32/0", log_rdn[1], overlap); else passed++;
`endif
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int cy; bit ok;
    ok = 1'b0;
    clear_logs();
    rd_ready = 1'b1;
    issue_req(1'b0, 1'b1, 30'h1000, 24'd40);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_n >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL ovf_progress: got %0d beats want at least 5", rd_n); else passed++;
    @(posedge clk); #2;
    p_rd_overflow = 1'b1;
    @(negedge clk);
    total++; if (p_rd_en !== 1'b0 || p_cmd_en !== 1'b0) $display("FAIL ovf_enables: got rd_en %b cmd_en %b want 0/0", p_rd_en, p_cmd_en); else passed++;
    wait_done(5, cy, ok);
    total++; if (!ok || error !== 1'b1) $display("FAIL ovf_done: got ok %b error %b want 1/1", ok, error); else passed++;
    p_rd_overflow = 1'b0;
    rd_ready = 1'b0;
    step(2);
    @(negedge clk);
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL ovf_idle: got busy %b req_ready %b want 0/1", busy, req_ready); else passed++;
    total++; if (done_wide !== 0) $display("FAIL done_width: got %0d wide pulses want 0", done_wide); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read_70();
    test_cmd_full();
    test_rd_gaps();
    test_bad_req();
    test_read_64();
    test_overflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
